puf_uart_top: RTL and testbench
===============================

// Module: puf_uart_top
// PURPOSE
// - Top of the PUF challenge/response path. Receives a 128-bit challenge over UART on rxd.
// - Computes a deterministic, key-emulated PUF response.
// - Returns the response over UART on txd. Contains a UART RX, a UART TX, a byte assembler and a control FSM.
// PARAMETERS
// - CLKS_PER_BIT   868              clk cycles per UART bit (100 MHz / 115200)
// - DEVICE_KEY     128'hA5A5_..._A5 per-device secret; emulates silicon variation (16 x 8'hA5)
// - TIMEOUT_BITS   32               idle bit-times mid-challenge before partial challenge is dropped
// PORTS
// - clk    in  1  system clock, all logic on posedge
// - rst_n  in  1  asynchronous active-low reset
// - rxd    in  1  UART serial in, 8N1, idle high, asynchronous to clk
// - txd    out 1  UART serial out, 8N1, idle high
// BEHAVIOUR
// - Reset state (async on rst_n=0):
//   - txd=1; byte count=0; challenge/response regs=0; FSM=IDLE.
//   - Both rxd synchronizer flops set to 1.
// - rxd input:
//   - Passes through a 2-flop synchronizer.
//   - A falling edge in idle starts a frame.
//   - The start bit is re-checked at CLKS_PER_BIT/2; if high, it is a glitch and the receiver returns to idle.
// - Data bit sampling:
//   - Data bits are sampled LSB first at bit centres.
//   - The stop bit is sampled at its centre. Stop=0 means framing error: the byte is discarded and the count is unchanged.
// - Byte assembly:
//   - Received byte k (k=0..15) is written to challenge[8k+7:8k], so the first byte is the LSB.
// - FSM IDLE -> RECV -> COMPUTE -> SEND -> IDLE.
//   - IDLE->RECV: on the first valid byte.
//   - RECV->COMPUTE: when the 16th valid byte is stored.
//   - COMPUTE: lasts exactly 1 cycle; response = challenge ^ DEVICE_KEY.
//   - SEND: starts on the next cycle; txd start bit within 2 clk of the 16th stop-bit sample.
// - SEND:
//   - 16 bytes, response[7:0] first, each 8N1 LSB first.
//   - Bytes are back-to-back with no idle gap between the stop bit and the next start bit.
//   - After the final stop bit: go to IDLE with count=0.
// - RECV timeout:
//   - If no valid byte arrives for TIMEOUT_BITS*CLKS_PER_BIT cycles, count=0 and FSM returns to IDLE.
//   - A partially received challenge is discarded.
// - Bytes arriving during COMPUTE/SEND are received but dropped; they never start a new challenge.
// - Reset mid-frame:
//   - Aborts both RX and TX immediately.
//   - txd goes to 1 asynchronously, with no truncated-frame recovery.
// - Counters:
//   - Bit-timer width is clog2(CLKS_PER_BIT*TIMEOUT_BITS).
//   - The bit counter wraps only via explicit reload, never by overflow.
// CONFIGURATION
// - RESP_CHECKSUM_EN defined:
//   - After the 16 response bytes, a 17th byte is sent: the XOR of all 16 response bytes.
//   - It is back-to-back like the others.
// - RESP_CHECKSUM_EN undefined:
//   - Exactly 16 bytes are sent; no checksum logic is present.
// TESTING
// - Reset check: rst_n low 5 cycles, rxd=1 -> txd=1 throughout; no frame emitted for 40 bit-times.
// - All-zero challenge: send 16 x 8'h00 -> returns 16 x 8'hA5.
//   - With RESP_CHECKSUM_EN, a 17th byte 8'h00 follows.
// - Worked example: send 128'h2d95031a235ae849a6e2668f5f906753, bytes LSB first 53,67,90,...,2d.
//   - Expected response 128'h8830a6bf86ff4dec0347c32afa35c2f6, first byte out f6.
// - Framing error: 8th byte sent with stop=0, followed by 9 good bytes.
//   - The response covers a challenge built from bytes 1-7 and 9-17; no response is sent after 16 frames.
// - Timeout: send 5 bytes, idle 33 bit-times, then send 16 new bytes -> exactly one response, using only the 16 new bytes.
// - Busy drop: send 16 bytes, then 4 more bytes during SEND.
//   - Exactly one response; the 4 extra bytes are not counted toward the next challenge.

Source files
------------

// File: rtl/puf_uart_top_if.sv
// Serial link between the PUF challenge/response block and its host.
//   rxd : host -> block, UART 8N1, idle high
//   txd : block -> host, UART 8N1, idle high
// master: host side (drives rxd, observes txd)
// slave : PUF block side (observes rxd, drives txd)
interface puf_uart_top_if;
    logic rxd;
    logic txd;

    modport master (output rxd, input txd);
    modport slave  (input rxd, output txd);
endinterface

// File: rtl/puf_uart_top.sv
// PUF challenge/response top: receives a 16-byte challenge over UART (first
// byte = challenge LSB), returns response = challenge ^ DEVICE_KEY over UART,
// 16 bytes back-to-back, response LSB byte first.
// Ports:
//   clk   : system clock, posedge
//   rst_n : asynchronous active-low reset
//   uart  : puf_uart_top_if.slave (rxd in, txd out)
// Optional feature macro RESP_CHECKSUM_EN: append a 17th byte holding the XOR
// of the 16 response bytes.
module puf_uart_top #(
    parameter int unsigned    CLKS_PER_BIT = 868,
    parameter logic [127:0]   DEVICE_KEY   = {16{8'hA5}},
    parameter int unsigned    TIMEOUT_BITS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    puf_uart_top_if.slave uart
);
    localparam int unsigned TMR_W        = $clog2(CLKS_PER_BIT * TIMEOUT_BITS);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * TIMEOUT_BITS;
`ifdef RESP_CHECKSUM_EN
    localparam logic [4:0]  LAST_BYTE    = 5'd16;
`else
    localparam logic [4:0]  LAST_BYTE    = 5'd15;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_COMPUTE, ST_SEND} state_e;

    logic             rxd_meta_q, rxd_meta_d;
    logic             rxd_sync_q, rxd_sync_d;
    logic             rxd_prev_q, rxd_prev_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [TMR_W-1:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_c;

    state_e           state_q, state_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0] idle_tmr_q, idle_tmr_d;
    logic [127:0]     challenge_q, challenge_d;
    logic [127:0]     response_q, response_d;
    logic [4:0]       tx_idx_q, tx_idx_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [TMR_W-1:0] tx_tmr_q, tx_tmr_d;
    logic             txd_q, txd_d;
    logic [7:0]       tx_byte_c;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]       checksum_q, checksum_d;
    logic [7:0]       checksum_c;
`endif

    assign uart.txd = txd_q;

    // UART receiver: 2-flop synchronizer, falling-edge start, centre sampling
    always_comb begin
        rxd_meta_d = uart.rxd;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
        rx_state_d = rx_state_q;
        rx_tmr_d   = rx_tmr_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_c = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tmr_d   = '0;
                end
            end
            RX_START: begin
                // start bit re-checked at mid-bit; still high means a glitch
                if (rx_tmr_q == TMR_W'(HALF_BIT - 1)) begin
                    rx_tmr_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_tmr_d = rx_tmr_q + TMR_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_tmr_q == TMR_W'(CLKS_PER_BIT - 1)) begin
                    rx_tmr_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_tmr_d = rx_tmr_q + TMR_W'(1);
                end
            end
            RX_STOP: begin
                // low stop bit is a framing error: byte silently dropped
                if (rx_tmr_q == TMR_W'(CLKS_PER_BIT - 1)) begin
                    rx_tmr_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_c = rxd_sync_q;
                end else begin
                    rx_tmr_d = rx_tmr_q + TMR_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Control FSM: byte assembly, timeout, response compute and transmit
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        idle_tmr_d  = idle_tmr_q;
        challenge_d = challenge_q;
        response_d  = response_q;
        tx_idx_d    = tx_idx_q;
        tx_bit_d    = tx_bit_q;
        tx_tmr_d    = tx_tmr_q;
        txd_d       = txd_q;
        tx_byte_c   = response_q[{tx_idx_q[3:0], 3'b000} +: 8];
`ifdef RESP_CHECKSUM_EN
        checksum_d  = checksum_q;
        checksum_c  = '0;
        for (int i = 0; i < 16; i++) begin
            checksum_c = checksum_c ^ challenge_q[8*i +: 8] ^ DEVICE_KEY[8*i +: 8];
        end
        if (tx_idx_q[4]) tx_byte_c = checksum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_c) begin
                    challenge_d[7:0] = rx_shift_q;
                    byte_cnt_d       = 5'd1;
                    idle_tmr_d       = '0;
                    state_d          = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_valid_c) begin
                    challenge_d[{byte_cnt_q[3:0], 3'b000} +: 8] = rx_shift_q;
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    idle_tmr_d = '0;
                    if (byte_cnt_q == 5'd15) state_d = ST_COMPUTE;
                end else if (idle_tmr_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
                    byte_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    idle_tmr_d = idle_tmr_q + TMR_W'(1);
                end
            end
            ST_COMPUTE: begin
                // start bit of byte 0 is launched together with the response
                response_d = challenge_q ^ DEVICE_KEY;
`ifdef RESP_CHECKSUM_EN
                checksum_d = checksum_c;
`endif
                tx_idx_d   = '0;
                tx_bit_d   = '0;
                tx_tmr_d   = '0;
                txd_d      = 1'b0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                // tx_bit_q: 0 = start, 1..8 = data, 9 = stop
                if (tx_tmr_q == TMR_W'(CLKS_PER_BIT - 1)) begin
                    tx_tmr_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_idx_q == LAST_BYTE) begin
                            txd_d      = 1'b1;
                            byte_cnt_d = '0;
                            state_d    = ST_IDLE;
                        end else begin
                            tx_idx_d = tx_idx_q + 5'd1;
                            tx_bit_d = '0;
                            txd_d    = 1'b0;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        txd_d    = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte_c[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_tmr_d = tx_tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_tmr_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            idle_tmr_q  <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            tx_idx_q    <= '0;
            tx_bit_q    <= '0;
            tx_tmr_q    <= '0;
            txd_q       <= 1'b1;
`ifdef RESP_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            rxd_prev_q  <= rxd_prev_d;
            rx_state_q  <= rx_state_d;
            rx_tmr_q    <= rx_tmr_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_tmr_q  <= idle_tmr_d;
            challenge_q <= challenge_d;
            response_q  <= response_d;
            tx_idx_q    <= tx_idx_d;
            tx_bit_q    <= tx_bit_d;
            tx_tmr_q    <= tx_tmr_d;
            txd_q       <= txd_d;
`ifdef RESP_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end
endmodule

// File: tb/tb_puf_uart_top.sv
// Self-checking bench for puf_uart_top: drives UART challenges on rxd,
// decodes txd frames and compares against challenge ^ key (plus optional
// XOR checksum when RESP_CHECKSUM_EN is defined).
module tb_puf_uart_top;
    localparam int unsigned CPB  = 8;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TOB  = 32;
`ifdef RESP_CHECKSUM_EN
    localparam int unsigned NRESP = 17;
`else
    localparam int unsigned NRESP = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned last_rx_start = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [7:0]  ch [16];
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_q [$];
    logic        mon_ok_q [$];
    int unsigned mon_start_q [$];

    puf_uart_top_if uart_if ();

    puf_uart_top #(
        .CLKS_PER_BIT (CPB),
        .DEVICE_KEY   ({16{8'hA5}}),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .uart  (uart_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // txd frame decoder: records byte, frame validity and start cycle
    initial begin : monitor
        logic [7:0] mb;
        logic       mstart;
        logic       mstop;
        forever begin
            @(negedge clk);
            if (rst_n && uart_if.txd == 1'b0) begin
                mon_start_q.push_back(cyc);
                repeat (HALF) @(negedge clk);
                mstart = uart_if.txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = uart_if.txd;
                end
                repeat (CPB) @(negedge clk);
                mstop = uart_if.txd;
                mon_q.push_back(mb);
                mon_ok_q.push_back(!mstart && mstop);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_if.rxd   = 1'b0;
        last_rx_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_if.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_if.rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_if.rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_chal();
        for (int i = 0; i < 16; i++) send_byte(ch[i], 1'b1);
    endtask

    task automatic rand_chal();
        for (int i = 0; i < 16; i++) ch[i] = 8'($urandom_range(0, 255));
    endtask

    // Reference: response byte i = challenge byte i ^ key byte (8'hA5)
    task automatic build_expect();
        logic [7:0] xs;
        xs = 8'h00;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ch[i] ^ 8'hA5);
            xs = xs ^ ch[i] ^ 8'hA5;
        end
`ifdef RESP_CHECKSUM_EN
        exp_q.push_back(xs);
`endif
    endtask

    task automatic clear_mon();
        mon_q.delete();
        mon_ok_q.delete();
        mon_start_q.delete();
    endtask

    task automatic check_latency(input string tag);
        int unsigned lat;
        for (int k = 0; k < 20 * CPB && mon_start_q.size() == 0; k++) @(negedge clk);
        check({tag, "_started"}, 32'(mon_start_q.size() > 0), 1);
        if (mon_start_q.size() > 0) begin
            lat = mon_start_q[0] - last_rx_start;
            check({tag, "_lat_lo"}, 32'(lat >= 9 * CPB + HALF), 1);
            check({tag, "_lat_hi"}, 32'(lat <= 9 * CPB + HALF + 6), 1);
        end
    endtask

    task automatic check_response(input string tag);
        int n;
        n = exp_q.size();
        for (int k = 0; k < (NRESP + 8) * 10 * CPB && mon_q.size() < n; k++) @(negedge clk);
        check({tag, "_count"}, 32'(mon_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < mon_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
                check($sformatf("%s_frame%0d", tag, i), 32'(mon_ok_q[i]), 1);
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i),
                          mon_start_q[i] - mon_start_q[i-1], 10 * CPB);
            end
        end
        repeat (20 * CPB) @(negedge clk);
        check({tag, "_no_extra"}, 32'(mon_q.size()), 32'(n));
        clear_mon();
    endtask

    initial begin : stim
        logic [127:0] wc;
        logic [127:0] wr;
        uart_if.rxd = 1'b1;
        rst_n       = 1'b0;

        // reset: txd idle high throughout, then no spontaneous frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset_txd%0d", i), 32'(uart_if.txd), 1);
        end
        rst_n = 1'b1;
        repeat (40 * CPB) @(negedge clk);
        check("reset_quiet", 32'(mon_q.size()), 0);

        // all-zero challenge
        for (int i = 0; i < 16; i++) ch[i] = 8'h00;
        build_expect();
        send_chal();
        check_latency("zero");
        check_response("zero");

        // worked example, expected response taken as a literal
        wc = 128'h2d95031a235ae849a6e2668f5f906753;
        wr = 128'h8830a6bf86ff4dec0347c32afa35c2f6;
        for (int i = 0; i < 16; i++) ch[i] = wc[8*i +: 8];
        build_expect();
        for (int i = 0; i < 16; i++) exp_q[i] = wr[8*i +: 8];
        send_chal();
        check_response("worked");

        // random challenges, the first preceded by a short rxd glitch
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                @(negedge clk);
                uart_if.rxd = 1'b0;
                repeat (2) @(negedge clk);
                uart_if.rxd = 1'b1;
                repeat (2 * CPB) @(negedge clk);
            end
            rand_chal();
            build_expect();
            send_chal();
            check_latency($sformatf("rand%0d", t));
            check_response($sformatf("rand%0d", t));
        end

        // framing error on the 8th frame: that byte must be skipped
        rand_chal();
        build_expect();
        for (int i = 0; i < 17; i++) begin
            if (i < 7)       send_byte(ch[i], 1'b1);
            else if (i == 7) send_byte(8'($urandom_range(0, 255)), 1'b0);
            else             send_byte(ch[i-1], 1'b1);
        end
        check_response("framing");

        // timeout drops a partial challenge
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        repeat (33 * CPB) @(negedge clk);
        check("timeout_silent", 32'(mon_q.size()), 0);
        rand_chal();
        build_expect();
        send_chal();
        check_response("timeout");

        // bytes during SEND are dropped and not counted afterwards
        rand_chal();
        build_expect();
        send_chal();
        check_latency("busy");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        check_response("busy");
        rand_chal();
        build_expect();
        send_chal();
        check_response("after_busy");

        // reset during transmission forces txd high asynchronously
        rand_chal();
        send_chal();
        for (int k = 0; k < 40 * CPB && mon_start_q.size() < 2; k++) @(negedge clk);
        check("rst_tx_started", 32'(mon_start_q.size() >= 2), 1);
        repeat (3 * CPB) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_txd", 32'(uart_if.txd), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        clear_mon();

        // partial challenge lost across reset, then a fresh one
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rand_chal();
        build_expect();
        send_chal();
        check_response("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
